quiz_round_ctrl: RTL and testbench
==================================

# quiz_round_ctrl

Round controller for the speed mental-conversion quiz. It turns the player's start/stop/submit buttons into the 2-bit `state` command that drives the LCG random-number stage, and captures the LCG's latched `random_num` as the round's question. It then times the player's answer, judges it against the answer switches, and keeps a saturating score. It sits directly upstream of the LCG (command source) and directly downstream of it (consumer of `random_num`).

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per countdown tick (1 s at 50 MHz); ≥2.
- `TIME_LIMIT`, 10: ticks allowed per question; 1..15.
- `MAX_SCORE`, 99: score saturation value; ≤127.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start_btn`  in  1  start level, already synchronised; rising edge starts the LCG spinning.
- `stop_btn`  in  1  stop level, already synchronised; rising edge freezes the question.
- `submit_btn`  in  1  submit level, already synchronised; rising edge submits `answer`.
- `answer`  in  4  player's answer switches.
- `random_num`  in  4  latched value from the LCG.
- `lcg_state`  out  2  LCG command: 1 = advance, 0 = latch to `random_num`, 2 = hold.
- `question`  out  4  captured question value.
- `time_left`  out  4  remaining ticks in the current question.
- `score`  out  7  correct-answer count, saturating.
- `phase`  out  2  0 = idle, 1 = spinning, 2 = asking.
- `correct`  out  1  one-cycle pulse when the answer is judged correct.
- `wrong`  out  1  one-cycle pulse when the answer is judged wrong.
- `timeout`  out  1  one-cycle pulse when time expires.

## Operation
- Edge detection:
  - Each button has a `prev` register with reset value 0.
  - The edge signal is `btn & ~prev` and is combinational within the cycle.
  - A button that is high when `rst` releases produces an edge on the first clock.
- FSM states:
  - IDLE: `lcg_state=2`, `phase=0`.
    - A start edge moves to SPIN.
    - Stop and submit edges are ignored.
  - SPIN: `lcg_state=1`, `phase=1`.
    - A stop edge moves to LATCH.
    - Start and submit edges are ignored.
    - If start and stop edges arrive together, stop wins.
  - LATCH: `lcg_state=0`, `phase=1`. Lasts exactly 1 cycle, then moves to CAPTURE.
  - CAPTURE: `lcg_state=2`, `phase=1`. Lasts exactly 1 cycle. On exit:
    - `question <= random_num`
    - `time_left <= TIME_LIMIT`
    - prescaler `<= 0`
    - move to ASK.
  - ASK: `lcg_state=2`, `phase=2`.
    - Submit edge: if `answer == question`, pulse `correct` and set `score <= min(score+1, MAX_SCORE)`. Otherwise pulse `wrong`. Then move to IDLE.
    - Timeout (see below): pulse `timeout`, leave `score` unchanged, move to IDLE.
    - If submit and timeout occur in the same cycle, submit wins and there is no `timeout` pulse.
    - Start and stop edges are ignored.
- Countdown, active in ASK only:
  - The prescaler counts 0..TICK_DIV-1; a tick fires on the cycle where it equals TICK_DIV-1, then it wraps to 0.
  - On a tick, `time_left` decrements.
  - A tick while `time_left == 1` is the timeout cycle.
  - Outside ASK the prescaler is held at 0 and `time_left` holds its value.
- `question` and `time_left` hold their values in IDLE so the display can show the last round.
- `score` is cleared only by `rst`.
- `lcg_state` and `phase` are decoded from the state register only (Moore). Pulses and counters are registered.
- Reset values:
  - state IDLE, `lcg_state=2`, `phase=0`
  - `question=0`, `time_left=0`, `score=0`
  - `correct=0`, `wrong=0`, `timeout=0`
  - all `prev` registers 0, prescaler 0.
- Asserting `rst` mid-round (any state) immediately forces all of the reset values above.

## Timing
- Start edge sampled at edge k: `lcg_state=1` from edge k.
- Stop edge sampled at edge j:
  - LATCH (`lcg_state=0`) from edge j.
  - The LCG updates `random_num` at edge j+1.
  - `question` is valid and `phase=2` from edge j+2.
- Submit edge sampled at edge s in ASK:
  - `correct`/`wrong` is high during cycle s..s+1 only.
  - `score` is updated at edge s.
  - `phase=0` from edge s.
- Timeout: with ASK entered at edge e, `timeout` is high for the cycle after edge e + TICK_DIV·TIME_LIMIT.
- At most one of `correct`/`wrong`/`timeout` is high in any cycle.

## Test plan
- Reset: assert `rst` asynchronously mid-clock -> all outputs take their reset values immediately, with `lcg_state=2`.
- Normal round (TICK_DIV=4, TIME_LIMIT=3): start, stop, bench drives `random_num=4'hA` after LATCH, submit with `answer=4'hA` -> `question=A`, one `correct` pulse, `score=1`, `phase=0`.
- Wrong and saturation: a round with `answer=5`, `question=A` -> one `wrong` pulse, `score` unchanged. Preload `score` to 99 via 99 correct rounds (MAX_SCORE=99) -> a further correct round keeps `score=99`.
- Timeout (TICK_DIV=4, TIME_LIMIT=3): enter ASK and never submit -> `time_left` steps 3,2,1, then `timeout` pulses exactly 12 cycles after ASK entry, `phase=0`, `score` unchanged.
- Simultaneous events:
  - Start and stop edges together in SPIN -> goes to LATCH.
  - Submit in the exact timeout cycle -> `correct`/`wrong` only, no `timeout`.
  - Stop or submit edges in IDLE -> no state change.
- Held buttons: hold `start_btn` high across reset release -> one start edge and SPIN. Keep holding -> no retrigger. Stop in SPIN while start is still held -> LATCH.

Source files
------------

// File: rtl/quiz_round_ctrl.sv
// Round controller for the speed mental-conversion quiz: drives the LCG command,
// captures the question, times the answer and keeps a saturating score.
module quiz_round_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int TIME_LIMIT = 10,
  parameter int MAX_SCORE  = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       submit_btn,
  input  logic [3:0] answer,
  input  logic [3:0] random_num,
  output logic [1:0] lcg_state,
  output logic [3:0] question,
  output logic [3:0] time_left,
  output logic [6:0] score,
  output logic [1:0] phase,
  output logic       correct,
  output logic       wrong,
  output logic       timeout
);

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]      LIMIT      = 4'(TIME_LIMIT);
  localparam logic [6:0]      SCORE_MAX  = 7'(MAX_SCORE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPIN,
    S_LATCH,
    S_CAPTURE,
    S_ASK
  } state_t;

  state_t        state, state_nxt;
  logic          start_prev, stop_prev, submit_prev;
  logic          start_edge, stop_edge, submit_edge;
  logic [PW-1:0] presc;
  logic          tick, expire;

  assign start_edge  = start_btn  & ~start_prev;
  assign stop_edge   = stop_btn   & ~stop_prev;
  assign submit_edge = submit_btn & ~submit_prev;

  // The final tick with one unit left is the timeout cycle.
  assign tick   = (state == S_ASK) && (presc == PRESC_LAST);
  assign expire = tick && (time_left == 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_prev  <= 1'b0;
      stop_prev   <= 1'b0;
      submit_prev <= 1'b0;
    end else begin
      start_prev  <= start_btn;
      stop_prev   <= stop_btn;
      submit_prev <= submit_btn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lcg_state = 2'd2;
    phase     = 2'd0;
    case (state)
      S_IDLE: begin
        if (start_edge) state_nxt = S_SPIN;
      end
      S_SPIN: begin
        lcg_state = 2'd1;
        phase     = 2'd1;
        if (stop_edge) state_nxt = S_LATCH;
      end
      S_LATCH: begin
        lcg_state = 2'd0;
        phase     = 2'd1;
        state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        phase     = 2'd1;
        state_nxt = S_ASK;
      end
      S_ASK: begin
        phase = 2'd2;
        if (submit_edge || expire) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Submit takes priority over an expiring timer in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      question  <= 4'd0;
      time_left <= 4'd0;
      score     <= 7'd0;
      presc     <= '0;
      correct   <= 1'b0;
      wrong     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      correct <= 1'b0;
      wrong   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        S_CAPTURE: begin
          question  <= random_num;
          time_left <= LIMIT;
          presc     <= '0;
        end
        S_ASK: begin
          presc <= (tick || state_nxt != S_ASK) ? '0 : presc + 1'b1;
          if (tick) time_left <= time_left - 4'd1;
          if (submit_edge) begin
            if (answer == question) begin
              correct <= 1'b1;
              if (score < SCORE_MAX) score <= score + 7'd1;
            end else begin
              wrong <= 1'b1;
            end
          end else if (expire) begin
            timeout <= 1'b1;
          end
        end
        default: presc <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Scoreboard bench for quiz_round_ctrl: stimulus queues expected pulses, a
// monitor pops and compares them whenever correct/wrong/timeout fires.
module tb_quiz_round_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int TIME_LIMIT = 3;
  localparam int MAX_SCORE  = 99;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0, stop_btn = 1'b0, submit_btn = 1'b0;
  logic [3:0] answer = 4'd0, random_num = 4'd0;
  logic [1:0] lcg_state, phase;
  logic [3:0] question, time_left;
  logic [6:0] score;
  logic       correct, wrong, timeout;

  typedef struct {
    int kind;
    int score;
    int question;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   model_score  = 0;

  quiz_round_ctrl #(
    .TICK_DIV(TICK_DIV), .TIME_LIMIT(TIME_LIMIT), .MAX_SCORE(MAX_SCORE)
  ) dut (
    .clk(clk), .rst(rst),
    .start_btn(start_btn), .stop_btn(stop_btn), .submit_btn(submit_btn),
    .answer(answer), .random_num(random_num),
    .lcg_state(lcg_state), .question(question), .time_left(time_left),
    .score(score), .phase(phase),
    .correct(correct), .wrong(wrong), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic p, input logic b, input logic [3:0] ans);
    start_btn  = s;
    stop_btn   = p;
    submit_btn = b;
    answer     = ans;
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check_output({tag, "_lcg_state"}, lcg_state, 2);
    check_output({tag, "_phase"}, phase, 0);
    check_output({tag, "_question"}, question, 0);
    check_output({tag, "_time_left"}, time_left, 0);
    check_output({tag, "_score"}, score, 0);
    check_output({tag, "_pulses"}, {correct, wrong, timeout}, 0);
  endtask

  task automatic expect_submit(input logic [3:0] ans, input logic [3:0] q);
    exp_t e;
    if (ans == q) begin
      if (model_score < MAX_SCORE) model_score++;
      e.kind = 1;
    end else begin
      e.kind = 2;
    end
    e.score    = model_score;
    e.question = q;
    sb_q.push_back(e);
  endtask

  // Start, stop, supply the LCG value, and land in ASK.
  task automatic enter_ask(input logic [3:0] rnd);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0);
    check_output("spin_lcg", lcg_state, 1);
    check_output("spin_phase", phase, 1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0);
    check_output("latch_lcg", lcg_state, 0);
    check_output("latch_phase", phase, 1);
    random_num = rnd;
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0);
    check_output("capture_lcg", lcg_state, 2);
    check_output("capture_phase", phase, 1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0);
    check_output("ask_phase", phase, 2);
    check_output("ask_question", question, int'(rnd));
    check_output("ask_time_left", time_left, TIME_LIMIT);
  endtask

  task automatic play_round(input logic [3:0] rnd, input logic [3:0] ans);
    enter_ask(rnd);
    expect_submit(ans, rnd);
    apply_stimulus(1'b0, 1'b0, 1'b1, ans);
    check_output("after_submit_phase", phase, 0);
    check_output("after_submit_score", score, model_score);
    apply_stimulus(1'b0, 1'b0, 1'b0, ans);
    check_output("idle_phase", phase, 0);
  endtask

  // Monitor: every result pulse must match the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    int   kind;
    forever begin
      @(negedge clk);
      if (!rst && (correct || wrong || timeout)) begin
        check_output("pulse_onehot", int'(correct) + int'(wrong) + int'(timeout), 1);
        kind = correct ? 1 : (wrong ? 2 : 3);
        if (sb_q.size() == 0) begin
          check_output("unexpected_pulse_kind", kind, 0);
        end else begin
          e = sb_q.pop_front();
          check_output("pulse_kind", kind, e.kind);
          check_output("pulse_score", score, e.score);
          check_output("pulse_question", question, e.question);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    exp_t e;
    repeat (2) @(negedge clk);
    check_reset("reset_init");
    rst = 1'b0;
    @(negedge clk);
    check_output("idle_after_reset_phase", phase, 0);

    // Normal correct round, then a wrong answer against the same question.
    play_round(4'hA, 4'hA);
    check_output("normal_score", score, 1);
    play_round(4'hA, 4'h5);
    check_output("wrong_score", score, 1);

    // Stop and submit edges in IDLE do nothing.
    apply_stimulus(1'b0, 1'b1, 1'b0, 4'hA);
    check_output("idle_stop_phase", phase, 0);
    check_output("idle_stop_lcg", lcg_state, 2);
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'hA);
    apply_stimulus(1'b0, 1'b0, 1'b1, 4'hA);
    check_output("idle_submit_phase", phase, 0);
    check_output("idle_submit_pulses", {correct, wrong, timeout}, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'hA);

    // Timeout: time_left steps 3,2,1 then timeout exactly 12 cycles after ASK entry.
    enter_ask(4'h6);
    for (int k = 1; k <= 11; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0);
      check_output($sformatf("countdown_%0d", k), time_left, TIME_LIMIT - k / TICK_DIV);
      check_output($sformatf("countdown_to_%0d", k), timeout, 0);
    end
    e.kind = 3; e.score = model_score; e.question = 6;
    sb_q.push_back(e);
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0);
    check_output("timeout_pulse", timeout, 1);
    check_output("timeout_phase", phase, 0);
    check_output("timeout_time_left", time_left, 0);
    check_output("timeout_score", score, 1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0);
    check_output("timeout_pulse_width", timeout, 0);

    // Submit in the exact timeout cycle: only correct.
    enter_ask(4'h7);
    repeat (11) apply_stimulus(1'b0, 1'b0, 1'b0, 4'h7);
    expect_submit(4'h7, 4'h7);
    apply_stimulus(1'b0, 1'b0, 1'b1, 4'h7);
    check_output("race_correct", correct, 1);
    check_output("race_timeout", timeout, 0);
    check_output("race_phase", phase, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'h7);

    // Start and stop edges together while spinning: stop wins.
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0);
    check_output("both_pre_lcg", lcg_state, 1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 4'd0);
    check_output("both_lcg", lcg_state, 0);
    random_num = 4'h3;
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0);
    check_output("both_question", question, 3);
    expect_submit(4'h3, 4'h3);
    apply_stimulus(1'b0, 1'b0, 1'b1, 4'h3);
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'h3);
    check_output("both_score", score, 3);

    // Saturation at MAX_SCORE.
    while (model_score < MAX_SCORE) play_round(4'h9, 4'h9);
    check_output("sat_reach", score, MAX_SCORE);
    play_round(4'h9, 4'h9);
    check_output("sat_hold", score, MAX_SCORE);

    // Asynchronous reset mid-clock while asking.
    enter_ask(4'h2);
    #2 rst = 1'b1;
    #1 check_reset("reset_async");
    model_score = 0;
    start_btn = 1'b1;
    @(negedge clk);

    // Start held across reset release: one edge, no retrigger.
    rst = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd5);
    check_output("held_spin_phase", phase, 1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd5);
    check_output("held_still_spin", lcg_state, 1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 4'd5);
    check_output("held_latch", lcg_state, 0);
    random_num = 4'h5;
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd5);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd5);
    check_output("held_ask_phase", phase, 2);
    expect_submit(4'h5, 4'h5);
    apply_stimulus(1'b1, 1'b0, 1'b1, 4'd5);
    check_output("held_submit_phase", phase, 0);
    check_output("held_submit_score", score, 1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd5);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd5);
    check_output("held_no_retrigger", phase, 0);

    apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0);
    #1;
    check_output("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
